// File: rtl/vx_l1_mem_sched_if.sv
// Bundle for the two cache memory sides and the shared socket memory port.
// master drives cache requests / memory responses; slave is the scheduler.
interface vx_l1_mem_sched_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 512,
  parameter int TAG_WIDTH  = 8
);
  logic [1:0]                  in_req_valid;
  logic [1:0]                  in_req_rw;
  logic [2*ADDR_WIDTH-1:0]     in_req_addr;
  logic [2*DATA_WIDTH-1:0]     in_req_data;
  logic [2*DATA_WIDTH/8-1:0]   in_req_byteen;
  logic [2*TAG_WIDTH-1:0]      in_req_tag;
  logic [1:0]                  in_req_ready;

  logic                        out_req_valid;
  logic                        out_req_rw;
  logic [ADDR_WIDTH-1:0]       out_req_addr;
  logic [DATA_WIDTH-1:0]       out_req_data;
  logic [DATA_WIDTH/8-1:0]     out_req_byteen;
  logic [TAG_WIDTH:0]          out_req_tag;
  logic                        out_req_ready;

  logic                        out_rsp_valid;
  logic [DATA_WIDTH-1:0]       out_rsp_data;
  logic [TAG_WIDTH:0]          out_rsp_tag;
  logic                        out_rsp_ready;

  logic [1:0]                  in_rsp_valid;
  logic [DATA_WIDTH-1:0]       in_rsp_data;
  logic [TAG_WIDTH-1:0]        in_rsp_tag;
  logic [1:0]                  in_rsp_ready;

  modport master (
    output in_req_valid, in_req_rw, in_req_addr,
    output in_req_data, in_req_byteen, in_req_tag,
    input  in_req_ready,
    input  out_req_valid, out_req_rw, out_req_addr,
    input  out_req_data, out_req_byteen, out_req_tag,
    output out_req_ready,
    output out_rsp_valid, out_rsp_data, out_rsp_tag,
    input  out_rsp_ready,
    input  in_rsp_valid, in_rsp_data, in_rsp_tag,
    output in_rsp_ready
  );

  modport slave (
    input  in_req_valid, in_req_rw, in_req_addr,
    input  in_req_data, in_req_byteen, in_req_tag,
    output in_req_ready,
    output out_req_valid, out_req_rw, out_req_addr,
    output out_req_data, out_req_byteen, out_req_tag,
    input  out_req_ready,
    input  out_rsp_valid, out_rsp_data, out_rsp_tag,
    output out_rsp_ready,
    output in_rsp_valid, in_rsp_data, in_rsp_tag,
    input  in_rsp_ready
  );
endinterface

// File: rtl/vx_l1_mem_sched.sv
// Shares the L1->L2 port between icache (0) and dcache (1): fixed priority
// with a dcache starvation override, per-source read caps, tag routing.
module vx_l1_mem_sched #(
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 512,
  parameter int TAG_WIDTH    = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_PENDING  = 8
) (
  input  logic clk,
  input  logic reset,
  vx_l1_mem_sched_if.slave bus,
  output logic busy
);
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = DATA_WIDTH / 8;

  logic [1:0][PW-1:0]    pending;
  logic [SW-1:0]         starve_cnt;
  logic [1:0]            elig;
  logic [1:0]            gnt;
  logic [1:0]            acc;
  logic [1:0]            inc;
  logic [1:0]            dec;
  logic                  can_load;
  logic                  force_d;
  logic                  sel;
  logic                  rsp_src;

  logic                  req_valid;
  logic                  req_rw;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic [BW-1:0]         req_be;
  logic [TAG_WIDTH:0]    req_tag;

  always_comb begin
    elig = '0;
    for (int s = 0; s < 2; s++) begin
      elig[s] = bus.in_req_valid[s] &
                (bus.in_req_rw[s] | (pending[s] < PW'(MAX_PENDING)));
    end
  end

  assign can_load = ~req_valid | bus.out_req_ready;
  assign force_d  = (starve_cnt == SW'(STARVE_LIMIT)) & elig[1];

  always_comb begin
    gnt = 2'b00;
    if (force_d)      gnt = 2'b10;
    else if (elig[0]) gnt = 2'b01;
    else if (elig[1]) gnt = 2'b10;
  end

  assign acc = gnt & {2{can_load & ~reset}};
  assign sel = gnt[1];
  assign bus.in_req_ready = acc;

  // Blocked means eligible but not actually handed off this cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (elig[1] & ~acc[1]) begin
      if (starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                  req_valid <= 1'b0;
    else if (|acc)              req_valid <= 1'b1;
    else if (bus.out_req_ready) req_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (|acc) begin
      req_rw   <= bus.in_req_rw[sel];
      req_addr <= bus.in_req_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
      req_data <= bus.in_req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
      req_be   <= bus.in_req_byteen[int'(sel)*BW +: BW];
      req_tag  <= {bus.in_req_tag[int'(sel)*TAG_WIDTH +: TAG_WIDTH], sel};
    end
  end

  assign bus.out_req_valid  = req_valid;
  assign bus.out_req_rw     = req_rw;
  assign bus.out_req_addr   = req_addr;
  assign bus.out_req_data   = req_data;
  assign bus.out_req_byteen = req_be;
  assign bus.out_req_tag    = req_tag;

  assign rsp_src = bus.out_rsp_tag[0];

  always_comb begin
    inc = '0;
    dec = '0;
    for (int s = 0; s < 2; s++) begin
      inc[s] = acc[s] & ~bus.in_req_rw[s];
      dec[s] = bus.out_rsp_valid & bus.in_rsp_ready[s] &
               (int'(rsp_src) == s);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (inc[s] & ~dec[s])
          pending[s] <= pending[s] + 1'b1;
        else if (dec[s] & ~inc[s])
          pending[s] <= pending[s] - 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < 2; s++) begin
        assert (!(dec[s] && pending[s] == '0))
          else $error("pending underflow on source %0d", s);
      end
    end
  end

  assign bus.in_rsp_valid  = {bus.out_rsp_valid & rsp_src,
                              bus.out_rsp_valid & ~rsp_src};
  assign bus.in_rsp_data   = bus.out_rsp_data;
  assign bus.in_rsp_tag    = bus.out_rsp_tag[TAG_WIDTH:1];
  assign bus.out_rsp_ready = bus.in_rsp_ready[rsp_src];

  assign busy = req_valid | (|pending[0]) | (|pending[1]);
endmodule

// File: tb/tb_vx_l1_mem_sched.sv
// Randomized scoreboard bench for vx_l1_mem_sched against a
// cycle-level arbitration model kept as plain integers and queues.
module tb_vx_l1_mem_sched;
  localparam int AW = 26;
  localparam int DW = 512;
  localparam int TW = 8;
  localparam int SL = 4;
  localparam int MP = 8;
  localparam int BW = DW / 8;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    logic [TW:0]   tag;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  vx_l1_mem_sched_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  vx_l1_mem_sched #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
    .STARVE_LIMIT(SL), .MAX_PENDING(MP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int chk = 0;
  int err = 0;

  req_t        expq[$];
  logic [TW:0] rspq[$];

  int pend[2];
  int starve;
  bit ov;

  logic          cur_rsp_v;
  logic [TW:0]   cur_rsp_tag;
  logic [DW-1:0] cur_rsp_data;

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic bit pct(int p);
    return $urandom_range(99) < p;
  endfunction

  task automatic model_clear();
    pend[0] = 0;
    pend[1] = 0;
    starve = 0;
    ov = 0;
    expq.delete();
    rspq.delete();
  endtask

  // One cycle of random traffic; model predicts this cycle's grant
  task automatic step(int pv, int pw, int pr, int prsp, int prr);
    logic [1:0] v, rw, er;
    req_t       r[2];
    int         idx, g;
    bit         can, rh;
    logic       src;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      v[s] = pct(pv);
      rw[s] = pct(pw);
      r[s].rw = rw[s];
      r[s].addr = AW'($urandom());
      r[s].data = rnd_data();
      r[s].be = {$urandom(), $urandom()};
      r[s].tag = {TW'($urandom()), 1'(s)};
      bus.in_req_addr[s*AW +: AW] = r[s].addr;
      bus.in_req_data[s*DW +: DW] = r[s].data;
      bus.in_req_byteen[s*BW +: BW] = r[s].be;
      bus.in_req_tag[s*TW +: TW] = r[s].tag[TW:1];
    end
    bus.in_req_valid = v;
    bus.in_req_rw = rw;
    bus.out_req_ready = pct(pr);
    idx = -1;
    if (rspq.size() > 0 && pct(prsp)) idx = $urandom_range(rspq.size() - 1);
    cur_rsp_v = (idx >= 0);
    cur_rsp_tag = (idx >= 0) ? rspq[idx] : (TW+1)'($urandom());
    cur_rsp_data = rnd_data();
    bus.out_rsp_valid = cur_rsp_v;
    bus.out_rsp_tag = cur_rsp_tag;
    bus.out_rsp_data = cur_rsp_data;
    bus.in_rsp_ready = {pct(prr), pct(prr)};
    #1;
    can = !ov || bus.out_req_ready;
    g = -1;
    if (can) begin
      if (starve == SL && v[1] && (rw[1] || pend[1] < MP)) g = 1;
      else if (v[0] && (rw[0] || pend[0] < MP)) g = 0;
      else if (v[1] && (rw[1] || pend[1] < MP)) g = 1;
    end
    er = (g >= 0) ? 2'(1 << g) : 2'b00;
    check("in_req_ready", DW'(bus.in_req_ready), DW'(er));
    check("out_req_valid", DW'(bus.out_req_valid), DW'(ov));
    check("busy", DW'(busy), DW'(ov || pend[0] != 0 || pend[1] != 0));
    if (v[1] && (rw[1] || pend[1] < MP) && g != 1)
      starve = (starve < SL) ? starve + 1 : SL;
    else
      starve = 0;
    if (g >= 0) begin
      expq.push_back(r[g]);
      if (!rw[g]) pend[g]++;
    end
    src = cur_rsp_tag[0];
    rh = cur_rsp_v && bus.in_rsp_ready[src];
    if (rh) begin
      pend[src]--;
      rspq.delete(idx);
    end
    ov = (g >= 0) || (ov && !bus.out_req_ready);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_req_valid = 2'b11;
    bus.in_req_rw = 2'b00;
    bus.out_req_ready = 1'b0;
    bus.out_rsp_valid = 1'b0;
    cur_rsp_v = 1'b0;
    #1;
    check("rst_in_req_ready", DW'(bus.in_req_ready), '0);
    @(negedge clk);
    reset = 1'b0;
    bus.in_req_valid = 2'b00;
    #1;
    check("rst_out_req_valid", DW'(bus.out_req_valid), '0);
    check("rst_busy", DW'(busy), '0);
    model_clear();
  endtask

  // Monitor: pops the scoreboard whenever the memory side takes a request
  initial begin
    req_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && bus.out_req_valid && bus.out_req_ready) begin
        if (expq.size() == 0) begin
          chk++;
          err++;
          $display("FAIL req_unexpected: got tag %h expected none",
                   bus.out_req_tag);
        end else begin
          e = expq.pop_front();
          check("out_req_rw", DW'(bus.out_req_rw), DW'(e.rw));
          check("out_req_addr", DW'(bus.out_req_addr), DW'(e.addr));
          check("out_req_data", bus.out_req_data, e.data);
          check("out_req_byteen", DW'(bus.out_req_byteen), DW'(e.be));
          check("out_req_tag", DW'(bus.out_req_tag), DW'(e.tag));
          if (!e.rw) rspq.push_back(e.tag);
        end
      end
      if (!reset) begin
        if (cur_rsp_v) begin
          check("in_rsp_valid", DW'(bus.in_rsp_valid),
                DW'(cur_rsp_tag[0] ? 2'b10 : 2'b01));
          check("in_rsp_tag", DW'(bus.in_rsp_tag), DW'(cur_rsp_tag[TW:1]));
          check("in_rsp_data", bus.in_rsp_data, cur_rsp_data);
          check("out_rsp_ready", DW'(bus.out_rsp_ready),
                DW'(bus.in_rsp_ready[cur_rsp_tag[0]]));
        end else begin
          check("in_rsp_idle", DW'(bus.in_rsp_valid), '0);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.in_req_valid = '0;
    bus.in_req_rw = '0;
    bus.in_req_addr = '0;
    bus.in_req_data = '0;
    bus.in_req_byteen = '0;
    bus.in_req_tag = '0;
    bus.out_req_ready = 1'b0;
    bus.out_rsp_valid = 1'b0;
    bus.out_rsp_data = '0;
    bus.out_rsp_tag = '0;
    bus.in_rsp_ready = '0;
    cur_rsp_v = 1'b0;
    cur_rsp_tag = '0;
    cur_rsp_data = '0;
    model_clear();
    do_reset();
    for (int i = 0; i < 300; i++) step(100, 0, 100, 60, 100);
    for (int i = 0; i < 1000; i++) step(70, 30, 50, 40, 70);
    for (int i = 0; i < 40; i++) step(90, 20, 100, 0, 100);
    for (int i = 0; i < 300; i++) step(100, 40, 30, 20, 50);
    for (int i = 0; i < 30; i++) step(90, 10, 100, 0, 100);
    do_reset();
    for (int i = 0; i < 500; i++) step(60, 30, 70, 50, 60);
    for (int i = 0; i < 5; i++) step(0, 0, 100, 0, 100);
    check("scoreboard_drained", DW'(expq.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end
endmodule
